// File: rtl/music_pkg.sv
// Shared music-player definitions: note store sequencer states and the default
// note width/depth used by the recorder, tone generator and display driver.
package music_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } seq_state_t;

  localparam int NOTE_WIDTH = 4;
  localparam int NOTE_DEPTH = 4;

endpackage : music_pkg

// File: rtl/note_seq_ram.sv
// Note-sequence memory: auto-incrementing record pointer, looping playback
// pointer, random-access display port and a self-timed one-entry-per-cycle clear.
module note_seq_ram
  import music_pkg::*;
#(
  parameter  int WIDTH = NOTE_WIDTH,
  parameter  int DEPTH = NOTE_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             step,
  input  logic [AW-1:0]    sel,
  output logic [WIDTH-1:0] q_ss,
  output logic [WIDTH-1:0] q_play,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             ovf
);

  seq_state_t       r_state;
  seq_state_t       w_state_next;
  logic [AW-1:0]    r_clr_idx;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_ovf;
  logic             r_busy;
  logic [WIDTH-1:0] r_q_play;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_idle;
  logic             w_wr_req;
  logic             w_wr_acc;
  logic             w_wr_drop;
  logic             w_step_acc;
  logic             w_rd_wrap;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_addr;
  logic [WIDTH-1:0] w_mem_data;
  logic [AW-1:0]    w_clr_idx_next;
  logic [AW-1:0]    w_wr_ptr_next;
  logic [AW-1:0]    w_rd_ptr_next;
  logic [AW:0]      w_count_next;
  logic             w_ovf_next;
  logic             w_full_next;
  logic             w_empty_next;
  logic [WIDTH-1:0] w_play_src;
  logic [WIDTH-1:0] w_q_play_next;

  assign w_idle     = (r_state == IDLE);
  assign w_wr_req   = we & load;
  assign w_wr_acc   = w_idle & w_wr_req & ~clr & ~r_full;
  assign w_wr_drop  = w_idle & w_wr_req & ~clr & r_full;
  assign w_step_acc = w_idle & step & ~clr & ~r_empty;
  // Playback loops over the recorded entries only, so the wrap uses the pre-edge count.
  assign w_rd_wrap  = ({1'b0, r_rd_ptr} == (r_count - (AW+1)'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (clr) w_state_next = CLEAR;
        else     w_state_next = IDLE;
      end
      CLEAR: begin
        if (clr)                                 w_state_next = CLEAR;
        else if (r_clr_idx == AW'(DEPTH - 1))    w_state_next = IDLE;
        else                                     w_state_next = CLEAR;
      end
      default: w_state_next = CLEAR;
    endcase
  end

  always_comb begin
    w_mem_we       = 1'b0;
    w_mem_addr     = r_wr_ptr;
    w_mem_data     = d;
    w_clr_idx_next = r_clr_idx;
    w_wr_ptr_next  = r_wr_ptr;
    w_rd_ptr_next  = r_rd_ptr;
    w_count_next   = r_count;
    w_ovf_next     = r_ovf;
    case (r_state)
      CLEAR: begin
        w_mem_we       = 1'b1;
        w_mem_addr     = r_clr_idx;
        w_mem_data     = '0;
        if (clr) w_clr_idx_next = '0;
        else     w_clr_idx_next = r_clr_idx + AW'(1);
      end
      IDLE: begin
        if (clr) begin
          w_clr_idx_next = '0;
          w_wr_ptr_next  = '0;
          w_rd_ptr_next  = '0;
          w_count_next   = '0;
          w_ovf_next     = 1'b0;
        end else begin
          if (w_wr_acc) begin
            w_mem_we      = 1'b1;
            w_wr_ptr_next = r_wr_ptr + AW'(1);
            w_count_next  = r_count + (AW+1)'(1);
          end else begin
            w_mem_we = 1'b0;
          end
          if (w_wr_drop) w_ovf_next = 1'b1;
          else           w_ovf_next = r_ovf;
          if (w_step_acc) begin
            if (w_rd_wrap) w_rd_ptr_next = '0;
            else           w_rd_ptr_next = r_rd_ptr + AW'(1);
          end else begin
            w_rd_ptr_next = r_rd_ptr;
          end
        end
      end
      default: begin
        w_clr_idx_next = '0;
      end
    endcase
  end

  assign w_full_next  = (w_count_next == (AW+1)'(DEPTH));
  assign w_empty_next = (w_count_next == (AW+1)'(0));
  // Forward a same-edge write so q_play reflects the post-edge memory.
  assign w_play_src    = (w_mem_we && (w_mem_addr == w_rd_ptr_next)) ? w_mem_data
                                                                      : r_mem[w_rd_ptr_next];
  assign w_q_play_next = w_empty_next ? '0 : w_play_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_idx <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b1;
      r_q_play  <= '0;
    end else begin
      r_clr_idx <= w_clr_idx_next;
      r_wr_ptr  <= w_wr_ptr_next;
      r_rd_ptr  <= w_rd_ptr_next;
      r_count   <= w_count_next;
      r_full    <= w_full_next;
      r_empty   <= w_empty_next;
      r_ovf     <= w_ovf_next;
      r_busy    <= (w_state_next == CLEAR);
      r_q_play  <= w_q_play_next;
    end
  end

  // Storage is deliberately unreset; the clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  assign q_ss   = r_mem[sel];
  assign q_play = r_q_play;
  assign count  = r_count;
  assign full   = r_full;
  assign empty  = r_empty;
  assign busy   = r_busy;
  assign ovf    = r_ovf;

endmodule : note_seq_ram

// File: tb/tb_note_seq_ram.sv
// Scoreboard bench for note_seq_ram: directed test-plan scenarios followed by
// randomized traffic, checked against a queue-level reference model.
module tb_note_seq_ram;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       we;
  logic       load;
  logic [3:0] d;
  logic       step;
  logic [1:0] sel;
  logic [3:0] q_ss;
  logic [3:0] q_play;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       busy;
  logic       ovf;

  note_seq_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .load(load), .d(d),
    .step(step), .sel(sel), .q_ss(q_ss), .q_play(q_play), .count(count),
    .full(full), .empty(empty), .busy(busy), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int q_ss;
    int q_play;
    int count;
    int full;
    int empty;
    int busy;
    int ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: recorded notes, pointers and remaining sweep length.
  int m_mem [DEPTH];
  int m_wr, m_rd, m_count, m_ovf, m_qplay, m_sweep_left;

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_count = 0; m_ovf = 0; m_qplay = 0;
    m_sweep_left = DEPTH;
  endtask

  task automatic model_edge();
    int old_count;
    if (rst) begin
      model_reset();
    end else if (m_sweep_left > 0) begin
      m_mem[DEPTH - m_sweep_left] = 0;
      if (clr) m_sweep_left = DEPTH;
      else     m_sweep_left = m_sweep_left - 1;
      m_qplay = 0;
    end else if (clr) begin
      m_sweep_left = DEPTH;
      m_wr = 0; m_rd = 0; m_count = 0; m_ovf = 0; m_qplay = 0;
    end else begin
      old_count = m_count;
      if (we && load) begin
        if (old_count < DEPTH) begin
          m_mem[m_wr] = int'(d);
          m_wr = (m_wr + 1) % DEPTH;
          m_count = m_count + 1;
        end else begin
          m_ovf = 1;
        end
      end
      if (step && old_count > 0) m_rd = (m_rd == old_count - 1) ? 0 : m_rd + 1;
      m_qplay = (m_count == 0) ? 0 : m_mem[m_rd];
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.q_ss   = m_mem[sel];
    e.q_play = m_qplay;
    e.count  = m_count;
    e.full   = (m_count == DEPTH) ? 1 : 0;
    e.empty  = (m_count == 0) ? 1 : 0;
    e.busy   = (m_sweep_left > 0) ? 1 : 0;
    e.ovf    = m_ovf;
    sb_q.push_back(e);
  endtask

  // One clock: model the edge with the sampled inputs, then drive the next inputs.
  task automatic cyc(input logic r, input logic c, input logic w, input logic l,
                     input logic s, input logic [3:0] dv, input logic [1:0] sv);
    @(posedge clk);
    model_edge();
    #1;
    rst = r; clr = c; we = w; load = l; step = s; d = dv; sel = sv;
    if (r) model_reset();
    push_expected();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'(i));
  endtask

  task automatic wr(input logic [3:0] dv, input logic [1:0] sv);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, dv, sv);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  exp_t mon_e;

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("busy",   int'(busy),   mon_e.busy);
      check("count",  int'(count),  mon_e.count);
      check("full",   int'(full),   mon_e.full);
      check("empty",  int'(empty),  mon_e.empty);
      check("ovf",    int'(ovf),    mon_e.ovf);
      check("q_play", int'(q_play), mon_e.q_play);
      if (mon_e.busy == 0) check("q_ss", int'(q_ss), mon_e.q_ss);
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; we = 1'b0; load = 1'b0; step = 1'b0; d = 4'd0; sel = 2'd0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = $urandom_range(0, 15);
    model_reset();

    // Reset release, sweep, then read all slots.
    idle_cycles(8);

    // Record 5, 9, 3 then step three times across the wrap.
    wr(4'd5, 2'd1); wr(4'd9, 2'd1); wr(4'd3, 2'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 2'd1);
    idle_cycles(2);

    // Fill, then overflow with 7.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    idle_cycles(5);
    wr(4'd1, 2'd0); wr(4'd2, 2'd0); wr(4'd3, 2'd0); wr(4'd4, 2'd0);
    wr(4'd7, 2'd0);
    idle_cycles(4);

    // Write and step together with one entry recorded.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    idle_cycles(5);
    wr(4'd6, 2'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd8, 2'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 2'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 2'd1);

    // clr together with a write request after two notes.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    idle_cycles(5);
    wr(4'd10, 2'd0); wr(4'd11, 2'd1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd12, 2'd2);
    idle_cycles(8);

    // Reset pulse mid-record.
    wr(4'd13, 2'd0); wr(4'd14, 2'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    idle_cycles(8);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < 5),
          ($urandom_range(0, 99) < 50),
          ($urandom_range(0, 99) < 75),
          ($urandom_range(0, 99) < 35),
          4'($urandom_range(0, 15)),
          2'($urandom_range(0, 3)));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_note_seq_ram

// File: doc/note_seq_ram.md
# note_seq_ram

Parametrised note-sequence memory for the music player: records notes into consecutive slots with an auto-incrementing write pointer, replays them in a loop through a stepped playback pointer, and exposes a random-access display read port. It replaces the fixed four-entry, 4-bit note store. It adds depth and width generics, an occupancy count with full/empty flags, wrap-around playback, and a self-timed clear sequencer that zeroes memory one entry per cycle. It sits between the keypad/record logic (writes), the tone generator (playback) and the seven-segment driver (display read).

## Interface
Parameters:
- WIDTH, 4, bits per note entry
- DEPTH, 4, number of entries; power of two, ≥2
- AW, $clog2(DEPTH), derived localparam; not overridable

Ports:
- clk  in  1  single system clock; all state updates on its rising edge
- rst  in  1  reset; asynchronous and active-high
- clr  in  1  start a clear sweep; level sampled each edge
- we  in  1  write enable
- load  in  1  write qualifier; a write is requested when we && load
- d  in  WIDTH  note to record
- step  in  1  advance playback pointer
- sel  in  AW  display read address
- q_ss  out  WIDTH  mem[sel], combinational
- q_play  out  WIDTH  registered note at playback pointer
- count  out  AW+1  entries recorded, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- busy  out  1  clear sweep in progress
- ovf  out  1  sticky: write requested while full

## Operation
- FSM states: IDLE, CLEAR. On rst the FSM enters CLEAR, so memory is zeroed after every reset.
- CLEAR:
  - Each cycle writes 0 to mem[clr_idx] and increments clr_idx.
  - After the edge that writes index DEPTH-1, the FSM moves to IDLE.
  - busy = 1 throughout CLEAR. Writes and steps are ignored.
- IDLE:
  - clr=1 → CLEAR with clr_idx=0. wr_ptr, rd_ptr, count and ovf are zeroed on the same edge.
- Write, accepted when IDLE && we && load && !clr && !full:
  - mem[wr_ptr] <= d.
  - wr_ptr <= wr_ptr+1. The pointer is AW bits wide and wraps naturally.
  - count <= count+1.
- Write request while full: data is dropped, no pointer change, ovf <= 1.
- Step, accepted when IDLE && step && !clr && !empty:
  - rd_ptr <= (rd_ptr == count-1) ? 0 : rd_ptr+1, using pre-edge count.
  - Step while empty is ignored.
- Simultaneous write and step: both take effect. The wrap test uses the old count.
- clr has priority over write and step on the same edge.
- clr asserted during CLEAR restarts the sweep at index 0.
- Memory array is not reset directly; the sweep clears it.

## Timing
- Reset values:
  - wr_ptr=0, rd_ptr=0, count=0, full=0, empty=1, ovf=0, q_play=0.
  - busy=1, state=CLEAR, clr_idx=0.
- Reset release: busy stays high for exactly DEPTH edges, then drops.
- q_ss: zero latency from sel. A write at edge N is visible from edge N onward.
- q_play <= empty_next ? 0 : mem_next[rd_ptr_next], giving one cycle of latency after a step or write.
- count, full, empty: registered; updated on the accepting edge.
- rst asserted mid-sweep or mid-record: immediately returns all state to the reset values above and restarts the sweep.

## Structure
- Shared package music_pkg holds:
  - the state typedef (IDLE, CLEAR);
  - default WIDTH/DEPTH constants, shared with the tone generator and display driver.
- Flat module; no sub-module. The pointer and sweep counters are inline.

## Test plan
All scenarios use WIDTH=4, DEPTH=4.
- Reset then wait: busy high for 4 cycles, then 0. Reading sel=0..3 gives q_ss=0. empty=1, count=0.
- Write 5, 9, 3, then step ×3: count=3, q_ss[sel=1]=9. q_play sequence is 5, 9, 3, 5 (wrap at count-1=2).
- Write 4 notes, then a 5th with d=7: full=1, count=4, ovf=1. mem[0] still holds its original value.
- Write and step on the same edge with count=1, rd_ptr=0: count→2 and rd_ptr stays 0 (old count wrap).
- After recording 2 notes, assert clr together with we&&load: the write is dropped. busy=1 for 4 cycles, then count=0, ovf=0 and all q_ss reads are 0.
- Assert rst for 1 cycle while two notes are recorded: count=0 immediately, q_play=0, and the sweep restarts (busy=1 for 4 cycles).
